// File: rtl/mem_pkg.sv
// Shared types and helpers for the line-granular memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GNT  = 2'd2
  } state_e;

  // Words per line from the log2 line size.
  function automatic int unsigned line_size(input int unsigned line_addr_len);
    return 32'(1) << line_addr_len;
  endfunction

  // Power-up value of word word_idx in line line_idx.
  function automatic word_t fill_word(input int unsigned line_idx,
                                      input int unsigned word_idx,
                                      input int unsigned line_addr_len);
    return WORD_W'((line_idx << line_addr_len) | word_idx);
  endfunction

endpackage : mem_pkg

// File: rtl/line_ram.sv
// Line-wide storage: one synchronous write port, one synchronous read port,
// no reset. Each line is kept XOR-ed with its power-up pattern, so an
// all-zero storage image at power-up reads back as the power-up fill.
module line_ram
  import mem_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_LEN = 3,
  parameter  int unsigned ADDR_LEN      = 8,
  localparam int unsigned LINE_SIZE     = line_size(LINE_ADDR_LEN)
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [ADDR_LEN-1:0]          waddr_i,
  input  word_t [LINE_SIZE-1:0]        wdata_i,
  input  logic [ADDR_LEN-1:0]          raddr_i,
  output word_t [LINE_SIZE-1:0]        rdata_o
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_LEN;

  typedef word_t [LINE_SIZE-1:0] line_t;

  line_t mem_q [DEPTH];
  line_t rdata_q;

  // Power-up pattern of a whole line.
  function automatic line_t fill_line(input logic [ADDR_LEN-1:0] a);
    line_t f;
    f = '0;
    for (int unsigned j = 0; j < LINE_SIZE; j++) begin
      f[LINE_ADDR_LEN'(j)] = fill_word(32'(a), j, LINE_ADDR_LEN);
    end
    return f;
  endfunction

  // Line write and registered line read; a same-edge read sees the old line.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i ^ fill_line(waddr_i);
    end
    rdata_q <= mem_q[raddr_i] ^ fill_line(raddr_i);
  end

  assign rdata_o = rdata_q;

endmodule : line_ram

// File: rtl/line_mem_responder.sv
// Main-memory responder: accepts a line read/write, waits LATENCY cycles,
// commits the write or returns the read line, and pulses gnt for one cycle.
module line_mem_responder
  import mem_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_LEN = 3,
  parameter  int unsigned ADDR_LEN      = 8,
  parameter  int unsigned LATENCY       = 50,
  localparam int unsigned LINE_SIZE     = line_size(LINE_ADDR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_LEN-1:0]   addr,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  word_t [LINE_SIZE-1:0] wr_line,
  output word_t [LINE_SIZE-1:0] rd_line,
  output logic                  gnt,
  output logic                  busy
);

  typedef word_t [LINE_SIZE-1:0] line_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                is_wr_q, is_wr_d;
  line_t               wline_q, wline_d;
  line_t               rd_line_q, rd_line_d;
  logic                gnt_q;
  logic                busy_q;

  logic                ram_we_c;
  logic [ADDR_LEN-1:0] ram_raddr_c;
  line_t               ram_rdata;

  // Read port follows the live address while idle so the line is already
  // fetched by the final BUSY edge, even at the minimum latency.
  assign ram_raddr_c = (state_q == IDLE) ? addr : addr_q;

  line_ram #(
    .LINE_ADDR_LEN (LINE_ADDR_LEN),
    .ADDR_LEN      (ADDR_LEN)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .waddr_i (addr_q),
    .wdata_i (wline_q),
    .raddr_i (ram_raddr_c),
    .rdata_o (ram_rdata)
  );

  // Next-state, request latching and completion actions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    wline_d   = wline_q;
    rd_line_d = rd_line_q;
    ram_we_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          addr_d  = addr;
          is_wr_d = wr_req;
          wline_d = wr_line;
          cnt_d   = CNT_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = GNT;
          if (is_wr_q) begin
            ram_we_c = 1'b1;
          end else begin
            rd_line_d = ram_rdata;
          end
        end
      end
      GNT: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      wline_q   <= '0;
      rd_line_q <= '0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      wline_q   <= wline_d;
      rd_line_q <= rd_line_d;
      gnt_q     <= (state_d == GNT);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign rd_line = rd_line_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;

endmodule : line_mem_responder

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder with a line-array reference model.
module tb_line_mem_responder;

  localparam int LAT = 4;
  localparam int LS  = 8;

  typedef logic [LS-1:0][31:0] line_t;
  typedef struct {
    line_t line;
    int    gcyc;
    string tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        rd_req;
  logic        wr_req;
  line_t       wr_line;
  line_t       rd_line;
  logic        gnt;
  logic        busy;

  int          cyc;
  int          n_tests;
  int          n_fail;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mdl [256][LS];
  line_t       last_rd;

  line_mem_responder #(
    .LINE_ADDR_LEN (3),
    .ADDR_LEN      (8),
    .LATENCY       (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .wr_line (wr_line),
    .rd_line (rd_line),
    .gnt     (gnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic line_t mdl_line(input int a);
    line_t r;
    for (int j = 0; j < LS; j++) r[j] = mdl[a][j];
    return r;
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int j = 0; j < LS; j++) r[j] = $urandom;
    return r;
  endfunction

  task automatic check_line(input string name, input line_t act, input line_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every gnt pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && gnt) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_gnt: gnt=1 at cycle %0d, required no gnt", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check_line({mon_e.tag, "_rd_line"}, rd_line, mon_e.line);
        check_int({mon_e.tag, "_gnt_cycle"}, cyc, mon_e.gcyc);
      end
    end
  end

  // Issue one request (called just after a rising edge), hold it until gnt,
  // and return in the cycle after gnt with the request still driven.
  task automatic issue(input bit rd, input bit wr, input logic [7:0] a,
                       input line_t d, input bit scramble);
    exp_t e;
    int   c0;
    bit   seen;
    addr    = a;
    rd_req  = rd;
    wr_req  = wr;
    wr_line = d;
    c0      = cyc;
    if (wr) begin
      for (int j = 0; j < LS; j++) mdl[a][j] = d[j];
    end else begin
      last_rd = mdl_line(a);
    end
    e.line = last_rd;
    e.gcyc = c0 + LAT;
    e.tag  = wr ? "wr" : "rd";
    sb_q.push_back(e);
    check_bit("busy_at_request", busy, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= LAT + 8 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (scramble && k == 2) begin
        addr    = 8'h10;
        wr_line = '0;
      end
      if (k <= LAT) check_bit("busy_during_op", busy, 1'b1);
      if (gnt) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_timeout: no gnt within %0d cycles of cycle %0d", LAT + 8, c0);
    end
    @(posedge clk);
    #1;
    check_bit("busy_after_gnt", busy, 1'b0);
  endtask

  task automatic go_idle(input int cycles);
    rd_req = 1'b0;
    wr_req = 1'b0;
    addr   = 8'($urandom);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    line_t d;
    logic [7:0] a;
    int op;

    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < LS; j++)
        mdl[i][j] = 32'((i << 3) | j);
    last_rd = '0;

    rst     = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    addr    = '0;
    wr_line = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_gnt", gnt, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_line("reset_rd_line", rd_line, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Power-up read of line 0x05.
    issue(1'b1, 1'b0, 8'h05, rand_line(), 1'b0);
    go_idle(2);

    // Write 0x05 then read it back in the cycle after the write gnt.
    for (int j = 0; j < LS; j++) d[j] = 32'(8'hA0 + j);
    issue(1'b0, 1'b1, 8'h05, d, 1'b0);
    issue(1'b1, 1'b0, 8'h05, rand_line(), 1'b0);
    go_idle(1);

    // Inputs changed during BUSY must not affect the write.
    issue(1'b0, 1'b1, 8'h03, rand_line(), 1'b1);
    go_idle(1);
    issue(1'b1, 1'b0, 8'h03, rand_line(), 1'b0);
    issue(1'b1, 1'b0, 8'h10, rand_line(), 1'b0);
    go_idle(1);

    // Continuous rd_req across two addresses.
    issue(1'b1, 1'b0, 8'h01, rand_line(), 1'b0);
    issue(1'b1, 1'b0, 8'h02, rand_line(), 1'b0);
    go_idle(6);

    // Reset two cycles into a write to 0x07.
    addr    = 8'h07;
    wr_req  = 1'b1;
    wr_line = rand_line();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_bit("midreset_gnt", gnt, 1'b0);
    check_bit("midreset_busy", busy, 1'b0);
    check_line("midreset_rd_line", rd_line, '0);
    last_rd = '0;
    wr_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    go_idle(1);
    issue(1'b1, 1'b0, 8'h07, rand_line(), 1'b0);
    go_idle(1);

    // Both requests high: write wins, rd_line unchanged.
    issue(1'b1, 1'b1, 8'h09, rand_line(), 1'b0);
    go_idle(1);
    issue(1'b1, 1'b0, 8'h09, rand_line(), 1'b0);
    go_idle(2);

    // Randomized traffic over a small address pool plus occasional far lines.
    for (int n = 0; n < 30; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if (op < 4)      issue(1'b0, 1'b1, a, rand_line(), 1'b0);
      else if (op < 9) issue(1'b1, 1'b0, a, rand_line(), 1'b0);
      else             issue(1'b1, 1'b1, a, rand_line(), 1'b0);
      go_idle($urandom_range(0, 2));
    end

    go_idle(10);
    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_line_mem_responder

// File: doc/line_mem_responder.md
# line_mem_responder

Line-granular main-memory responder answering the cache's line read/write requests on the gnt handshake. Holds 2^ADDR_LEN lines of 2^LINE_ADDR_LEN 32-bit words. A request is accepted, the block waits a fixed LATENCY, then the write is committed or the read line is returned, and gnt pulses for one cycle. Sits below the cache controller as the far end of its swap-in/swap-out interface.

## Interface
- LINE_ADDR_LEN, 3: log2 words per line; LINE_SIZE = 1 << LINE_ADDR_LEN.
- ADDR_LEN, 8: line address width (tag + set); depth = 1 << ADDR_LEN lines.
- LATENCY, 50: cycles from request sample to gnt; legal range 2..255.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  ADDR_LEN  line address, sampled at accept.
- rd_req  in  1  line read request, level, held until gnt.
- wr_req  in  1  line write request, level, held until gnt.
- wr_line  in  32 x LINE_SIZE  write line, sampled at accept.
- rd_line  out  32 x LINE_SIZE  read line, registered, reset 0.
- gnt  out  1  completion pulse, exactly one cycle, reset 0.
- busy  out  1  high while a request is in progress (BUSY or GNT), reset 0.

## Operation
- States: IDLE, BUSY, GNT; reset state IDLE; cnt 8-bit, reset 0.
- IDLE: if wr_req or rd_req, latch addr, op and wr_line; cnt <= 1; -> BUSY. wr_req and rd_req both high: write wins, read is dropped (requester must not do this).
- BUSY: cnt increments each cycle; when cnt == LATENCY-1 -> GNT, and on that same edge: write op stores latched line into array[latched addr]; read op loads rd_line <= array[latched addr].
- GNT: gnt = 1 (Moore, state == GNT); unconditionally -> IDLE.
- rd_line holds its value until the next read completes; writes never change it.
- Inputs are ignored outside IDLE; changing addr/wr_line/req during BUSY has no effect. A request dropped mid-BUSY still completes and still pulses gnt.
- Array contents: not affected by reset; simulation power-up value of word j of line i is (i << LINE_ADDR_LEN) | j.
- Reset asserted mid-operation: state IDLE, cnt 0, gnt 0, busy 0, rd_line 0 immediately; pending write discarded; array untouched.

## Timing
- Request high in cycle c0 (IDLE): gnt high in cycle c0+LATENCY only; rd_line valid from cycle c0+LATENCY onward; written data readable by any later request.
- IDLE again in cycle c0+LATENCY+1; a new request (e.g. read following a swap-out write) is sampled that cycle. Back-to-back throughput: one line per LATENCY+1 cycles.
- Requester sees gnt, advances on that edge and drops or changes req in the following cycle; the responder's return to IDLE aligns with this, so no request is double-accepted.
- busy rises the cycle after accept, falls the cycle after gnt.

## Structure
- Shared package mem_pkg: state enum (IDLE, BUSY, GNT), word type (32-bit), LINE_SIZE derivation helper, power-up fill function.
- Sub-module line_ram: 2^ADDR_LEN x LINE_SIZE x 32 storage, one synchronous line write port and one synchronous line read port, no reset; FSM, counter and latches live in the top.

## Test plan
- Defaults, LATENCY=4: reset, rd_req addr 0x05 in cycle c0 -> gnt only in c4, rd_line = {0x2F..0x28}, word j = 0x28+j; busy high c1..c4.
- wr_req addr 0x05 wr_line word j = 0xA0+j, then rd_req addr 0x05 in cycle after gnt -> write gnt at c4, read accepted at c5, gnt at c9, rd_line word j = 0xA0+j.
- Change addr to 0x10 and wr_line to zeros during BUSY of a write to 0x03 -> line 0x03 updated with original data, line 0x10 unchanged.
- Hold rd_req high continuously for addresses 0x01 then 0x02 -> exactly one gnt per LATENCY+1 cycles, never two accepts per gnt.
- Assert rst low two cycles into a write to 0x07 -> gnt, busy, rd_line all 0 at once; later read of 0x07 returns power-up values 0x38+j.
- rd_req and wr_req both high to addr 0x09 -> write performed, rd_line unchanged, single gnt.
